// File: rtl/in_port_ctrl.sv
// Purpose : processor input port; synchronizes an 8-bit switch bank, debounces the
//           load button and latches the switches into a holding register on each
//           debounced press, handing the value to the processor via valid/read strobe.
// Latency : button press to inData/inValid = DEBOUNCE_CYCLES+3 edges; switches 2 edges.
// Backpr. : no stall; a capture over an unread value replaces it and raises the
//           sticky overrun flag, which the next read strobe clears.
//
// Ports
//   clk       system clock
//   rst       asynchronous, active-high reset
//   swRaw     raw switch pins (asynchronous to clk)
//   btnRaw    raw load button, active-high (asynchronous to clk)
//   rdEn      one-cycle read strobe from the processor
//   inData    last captured switch value
//   inValid   inData holds a capture the processor has not read yet
//   overrun   sticky: a capture replaced an unread value
//   btnLevel  debounced button level (debug visibility)

module in_port_ctrl #(
    parameter int DEBOUNCE_CYCLES = 100_000,  // stable cycles to accept a level change, >= 2
    parameter int DATA_W          = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] swRaw,
    input  logic              btnRaw,
    input  logic              rdEn,
    output logic [DATA_W-1:0] inData,
    output logic              inValid,
    output logic              overrun,
    output logic              btnLevel
);

    // Counter only has to reach DEBOUNCE_CYCLES-1, so clog2 of the cycle count is enough.
    localparam int             CNT_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // ------------------------------------------------------------------
    // Two-flop synchronizers
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] swMeta_q;
    logic [DATA_W-1:0] swSync_q;
    logic              btnMeta_q;
    logic              btnSync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            swMeta_q  <= '0;
            swSync_q  <= '0;
            btnMeta_q <= 1'b0;
            btnSync_q <= 1'b0;
        end else begin
            swMeta_q  <= swRaw;
            swSync_q  <= swMeta_q;
            btnMeta_q <= btnRaw;
            btnSync_q <= btnMeta_q;
        end
    end

    // ------------------------------------------------------------------
    // Debouncer
    // ------------------------------------------------------------------
    // The synchronized button must disagree with the accepted level for
    // DEBOUNCE_CYCLES consecutive edges before the level follows it. Any
    // sample that agrees with the current level restarts the count, so a
    // glitch shorter than the window never reaches btnLevel.
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             btnLevel_q;
    logic             btnLevel_d;
    logic             btnLevelDly_q;

    always_comb begin
        cnt_d      = cnt_q;
        btnLevel_d = btnLevel_q;
        if (btnSync_q == btnLevel_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            btnLevel_d = btnSync_q;
            cnt_d      = '0;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            btnLevel_q    <= 1'b0;
            btnLevelDly_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            btnLevel_q    <= btnLevel_d;
            btnLevelDly_q <= btnLevel_q;
        end
    end

    // One-cycle pulse on each debounced rising edge; a release gives nothing.
    logic loadPulse;
    assign loadPulse = btnLevel_q & ~btnLevelDly_q;

    // ------------------------------------------------------------------
    // Holding register and handshake
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] inData_q;
    logic [DATA_W-1:0] inData_d;
    logic              inValid_q;
    logic              inValid_d;
    logic              overrun_q;
    logic              overrun_d;

    always_comb begin
        inData_d  = inData_q;
        inValid_d = inValid_q;
        overrun_d = overrun_q;
        if (loadPulse) begin
            // A capture always wins. If the processor reads in the same cycle
            // the old value counts as consumed, so no overrun is recorded.
            inData_d  = swSync_q;
            inValid_d = 1'b1;
            if (rdEn) begin
                overrun_d = 1'b0;
            end else if (inValid_q) begin
                overrun_d = 1'b1;
            end
        end else if (rdEn && inValid_q) begin
            // Data is left in place; only the flags are consumed.
            inValid_d = 1'b0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inData_q  <= '0;
            inValid_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            inData_q  <= inData_d;
            inValid_q <= inValid_d;
            overrun_q <= overrun_d;
        end
    end

    assign inData   = inData_q;
    assign inValid  = inValid_q;
    assign overrun  = overrun_q;
    assign btnLevel = btnLevel_q;

endmodule

// File: tb/tb_in_port_ctrl.sv
// Purpose : directed bench for in_port_ctrl with DEBOUNCE_CYCLES=4, DATA_W=8.
// Latency : each press expects its capture DEBOUNCE_CYCLES+3 edges after btnRaw rises.
// Backpr. : expected captures queue up at press time and are matched as the DUT shows them.

module tb_in_port_ctrl;

    localparam int DEB = 4;
    localparam int DW  = 8;

    logic          clk;
    logic          rst;
    logic [DW-1:0] swRaw;
    logic          btnRaw;
    logic          rdEn;
    logic [DW-1:0] inData;
    logic          inValid;
    logic          overrun;
    logic          btnLevel;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_dat;
    logic          prev_vld = 1'b0;
    logic [DW-1:0] prev_dat = '0;

    in_port_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .DATA_W         (DW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .swRaw   (swRaw),
        .btnRaw  (btnRaw),
        .rdEn    (rdEn),
        .inData  (inData),
        .inValid (inValid),
        .overrun (overrun),
        .btnLevel(btnLevel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_inData"},   inData,   32'h0);
        chk({tag, "_inValid"},  inValid,  32'h0);
        chk({tag, "_overrun"},  overrun,  32'h0);
        chk({tag, "_btnLevel"}, btnLevel, 32'h0);
    endtask

    task automatic read_pulse();
        rdEn = 1'b1;
        tick(1);
        rdEn = 1'b0;
    endtask

    // Scoreboard side: any new capture (valid rising or data replaced while
    // valid) must match the oldest outstanding expected value.
    always @(negedge clk) begin
        if (rst) begin
            prev_vld = 1'b0;
            prev_dat = '0;
        end else begin
            if (inValid === 1'b1 && (prev_vld !== 1'b1 || inData !== prev_dat)) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_capture: observed %0h, expected no capture", inData);
                end
                if (exp_q.size() != 0) begin
                    exp_dat = exp_q.pop_front();
                    chk("capture_data", inData, exp_dat);
                end
            end
            prev_vld = inValid;
            prev_dat = inData;
        end
    end

    int bounce[14] = '{1, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};

    initial begin
        rst    = 1'b1;
        swRaw  = 8'hFF;
        btnRaw = 1'b0;
        rdEn   = 1'b0;

        // Reset with switches all high, then idle
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk_all_zero("in_reset");
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk_all_zero("idle");
        end

        // Clean press: capture exactly after edge 6
        swRaw = 8'hA5;
        tick(3);
        btnRaw = 1'b1;
        exp_q.push_back(8'hA5);
        tick(5);
        chk("press_lvl_e4", btnLevel, 32'h0);
        tick(1);
        chk("press_lvl_e5", btnLevel, 32'h1);
        chk("press_vld_e5", inValid, 32'h0);
        tick(1);
        chk("press_vld_e6", inValid, 32'h1);
        chk("press_dat_e6", inData, 32'hA5);
        read_pulse();
        chk("read_vld", inValid, 32'h0);
        chk("read_dat", inData, 32'hA5);
        chk("read_ovr", overrun, 32'h0);
        btnRaw = 1'b0;
        tick(5);
        chk("release_lvl_e4", btnLevel, 32'h1);
        tick(1);
        chk("release_lvl_e5", btnLevel, 32'h0);
        tick(4);

        // Bounce rejection, then a 6-cycle hold gives exactly one capture
        swRaw = 8'h5A;
        for (int i = 0; i < 14; i++) begin
            btnRaw = 1'(bounce[i]);
            tick(1);
            chk("bounce_lvl", btnLevel, 32'h0);
            chk("bounce_vld", inValid, 32'h0);
        end
        btnRaw = 1'b1;
        exp_q.push_back(8'h5A);
        tick(6);
        btnRaw = 1'b0;
        chk("hold6_lvl", btnLevel, 32'h1);
        tick(1);
        chk("hold6_vld", inValid, 32'h1);
        chk("hold6_dat", inData, 32'h5A);
        tick(8);
        chk("hold6_release_lvl", btnLevel, 32'h0);
        chk("hold6_release_vld", inValid, 32'h1);
        read_pulse();
        chk("hold6_read_vld", inValid, 32'h0);

        // Overrun: second capture without an intervening read
        swRaw = 8'h11;
        tick(3);
        btnRaw = 1'b1;
        exp_q.push_back(8'h11);
        tick(8);
        chk("ovr_first_dat", inData, 32'h11);
        chk("ovr_first_ovr", overrun, 32'h0);
        btnRaw = 1'b0;
        tick(8);
        chk("ovr_release_vld", inValid, 32'h1);
        chk("ovr_release_lvl", btnLevel, 32'h0);
        swRaw = 8'h22;
        tick(3);
        btnRaw = 1'b1;
        exp_q.push_back(8'h22);
        tick(8);
        chk("ovr_second_dat", inData, 32'h22);
        chk("ovr_second_vld", inValid, 32'h1);
        chk("ovr_second_ovr", overrun, 32'h1);
        read_pulse();
        chk("ovr_read_vld", inValid, 32'h0);
        chk("ovr_read_ovr", overrun, 32'h0);
        chk("ovr_read_dat", inData, 32'h22);
        read_pulse();
        chk("idle_read_vld", inValid, 32'h0);
        chk("idle_read_dat", inData, 32'h22);
        btnRaw = 1'b0;
        tick(8);

        // Simultaneous capture and read, starting with overrun set
        swRaw = 8'h30;
        tick(3);
        btnRaw = 1'b1;
        exp_q.push_back(8'h30);
        tick(8);
        btnRaw = 1'b0;
        tick(8);
        swRaw = 8'h33;
        tick(3);
        btnRaw = 1'b1;
        exp_q.push_back(8'h33);
        tick(8);
        chk("sim_pre_dat", inData, 32'h33);
        chk("sim_pre_ovr", overrun, 32'h1);
        btnRaw = 1'b0;
        tick(8);
        swRaw = 8'h44;
        tick(3);
        btnRaw = 1'b1;
        exp_q.push_back(8'h44);
        tick(6);
        rdEn = 1'b1;
        tick(1);
        rdEn = 1'b0;
        chk("sim_dat", inData, 32'h44);
        chk("sim_vld", inValid, 32'h1);
        chk("sim_ovr", overrun, 32'h0);
        read_pulse();
        chk("sim_read_vld", inValid, 32'h0);
        btnRaw = 1'b0;
        tick(8);

        // Reset mid-count, then first capture 7 edges after release
        swRaw = 8'h55;
        tick(2);
        btnRaw = 1'b1;
        tick(4);
        rst = 1'b1;
        #1;
        chk_all_zero("rst_midcount");
        tick(2);
        chk_all_zero("rst_midcount_hold");
        rst = 1'b0;
        exp_q.push_back(8'h55);
        tick(6);
        chk("post_rst_vld_e5", inValid, 32'h0);
        tick(1);
        chk("post_rst_vld_e6", inValid, 32'h1);
        chk("post_rst_dat_e6", inData, 32'h55);

        // Reset while holding an unread value with overrun set
        btnRaw = 1'b0;
        tick(8);
        swRaw = 8'h66;
        tick(3);
        btnRaw = 1'b1;
        exp_q.push_back(8'h66);
        tick(8);
        chk("pre_rst_ovr", overrun, 32'h1);
        chk("pre_rst_lvl", btnLevel, 32'h1);
        chk("pre_rst_dat", inData, 32'h66);
        rst = 1'b1;
        #1;
        chk_all_zero("rst_async");
        btnRaw = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(10);
        chk_all_zero("final_idle");

        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
